// File: rtl/multdiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package multdiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  typedef enum logic [0:0] {
    OP_MULT = 1'b0,
    OP_DIV  = 1'b1
  } op_e;

  localparam int ITER  = 32;
  localparam int CNT_W = 5;

endpackage

// File: rtl/multdiv_step.sv
// One add/subtract-and-shift iteration on the 64-bit accumulator, built on
// the shared 32-bit adder (shift-add multiply or restoring divide).
module multdiv_step
  import multdiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   operand_i,
  input  op_e                op_i,
  output logic [2*WIDTH-1:0] acc_o
);

  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic             add_cin;
  logic [WIDTH:0]   sum;
  logic             fits;

  assign hi      = acc_i[2*WIDTH-1:WIDTH];
  assign lo      = acc_i[WIDTH-1:0];
  assign shifted = {hi, lo[WIDTH-1]};
  assign sum     = {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};

  // Divide subtracts as a + ~b + 1; the divisor fits when the 33-bit partial
  // remainder overflowed the adder width or the subtraction did not borrow.
  assign fits = shifted[WIDTH] | sum[WIDTH];

  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    acc_o   = acc_i;
    if (op_i == OP_MULT) begin
      add_a = hi;
      add_b = lo[0] ? operand_i : '0;
      acc_o = {sum, lo[WIDTH-1:1]};
    end else begin
      add_a   = shifted[WIDTH-1:0];
      add_b   = ~operand_i;
      add_cin = 1'b1;
      acc_o   = fits ? {sum[WIDTH-1:0], lo[WIDTH-2:0], 1'b1}
                     : {shifted[WIDTH-1:0], lo[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/zero_det.sv
// ALU zero detector: high when the input word is all zeros.
module zero_det #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] data,
  output logic             zero
);

  assign zero = ~|data;

endmodule

// File: rtl/multdiv_ctrl.sv
// Iterative 32-bit signed multiply/divide sequencer with one-cycle ready pulse.
// Optional MULTDIV_EARLY_ZERO_EN: multiplies with a zero operand finish in 1 cycle.
module multdiv_ctrl
  import multdiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITER - 1);

  state_e               state_q,   state_d;
  logic [CNT_W-1:0]     cnt_q,     cnt_d;
  op_e                  op_q,      op_d;
  logic                 sign_q,    sign_d;
  logic                 early_q,   early_d;
  logic [WIDTH-1:0]     operand_q, operand_d;
  logic [2*WIDTH-1:0]   acc_q,     acc_d;
  logic [WIDTH-1:0]     result_q,  result_d;
  logic                 exc_q,     exc_d;

  logic                 start;
  logic                 zero_b;
  logic                 early_mult;
  logic [WIDTH-1:0]     mag_a;
  logic [WIDTH-1:0]     mag_b;
  logic [2*WIDTH-1:0]   acc_next;
  logic [2*WIDTH-1:0]   prod_fixed;
  logic [WIDTH-1:0]     quo_fixed;

  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v);
    return (v < 0) ? WIDTH'(-v) : WIDTH'(v);
  endfunction

  // Product fits in WIDTH signed bits only if the upper bits are pure sign extension.
  function automatic logic mult_overflow(input logic signed [2*WIDTH-1:0] p);
    return !((&p[2*WIDTH-1:WIDTH-1]) || !(|p[2*WIDTH-1:WIDTH-1]));
  endfunction

  zero_det #(.WIDTH(WIDTH)) u_zero_b (.data(data_operandB), .zero(zero_b));

`ifdef MULTDIV_EARLY_ZERO_EN
  logic zero_a;
  zero_det #(.WIDTH(WIDTH)) u_zero_a (.data(data_operandA), .zero(zero_a));
  assign early_mult = zero_a | zero_b;
`else
  assign early_mult = 1'b0;
`endif

  multdiv_step #(.WIDTH(WIDTH)) u_step (
    .acc_i     (acc_q),
    .operand_i (operand_q),
    .op_i      (op_q),
    .acc_o     (acc_next)
  );

  assign start = ctrl_MULT | ctrl_DIV;
  assign mag_a = magnitude(signed'(data_operandA));
  assign mag_b = magnitude(signed'(data_operandB));

  assign prod_fixed = sign_q ? (2*WIDTH)'(-signed'(acc_q)) : acc_q;
  assign quo_fixed  = sign_q ? WIDTH'(-signed'(acc_q[WIDTH-1:0])) : acc_q[WIDTH-1:0];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    sign_d    = sign_q;
    early_d   = early_q;
    operand_d = operand_q;
    acc_d     = acc_q;
    result_d  = result_q;
    exc_d     = exc_q;

    case (state_q)
      IDLE: ;
      RUN: begin
        if (early_q) begin
          // Zero short-cut: only divide-by-zero raises the exception.
          state_d  = DONE;
          result_d = '0;
          exc_d    = (op_q == OP_DIV);
        end else begin
          acc_d = acc_next;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) state_d = FIX;
        end
      end
      FIX: begin
        state_d = DONE;
        if (op_q == OP_MULT) begin
          result_d = prod_fixed[WIDTH-1:0];
          exc_d    = mult_overflow(signed'(prod_fixed));
        end else begin
          result_d = quo_fixed;
          exc_d    = 1'b0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A start in any state launches a fresh op; an aborted op never reaches DONE.
    if (start) begin
      state_d = RUN;
      cnt_d   = '0;
      sign_d  = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      if (ctrl_MULT) begin
        op_d      = OP_MULT;
        operand_d = mag_a;
        acc_d     = {{WIDTH{1'b0}}, mag_b};
        early_d   = early_mult;
      end else begin
        op_d      = OP_DIV;
        operand_d = mag_b;
        acc_d     = {{WIDTH{1'b0}}, mag_a};
        early_d   = zero_b;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_q      <= OP_MULT;
      sign_q    <= 1'b0;
      early_q   <= 1'b0;
      operand_q <= '0;
      acc_q     <= '0;
      result_q  <= '0;
      exc_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      sign_q    <= sign_d;
      early_q   <= early_d;
      operand_q <= operand_d;
      acc_q     <= acc_d;
      result_q  <= result_d;
      exc_q     <= exc_d;
    end
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = (state_q == DONE);

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Self-checking bench for multdiv_ctrl: directed table, corner sequences, random ops.
module tb_multdiv_ctrl;

`ifdef MULTDIV_EARLY_ZERO_EN
  localparam int EZ_LAT = 1;
`else
  localparam int EZ_LAT = 33;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;

  int pass_cnt  = 0;
  int total_cnt = 0;

  multdiv_ctrl #(.WIDTH(32)) dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        is_mult;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_res;
    logic        exp_exc;
    int          exp_lat;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input longint act, input longint exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Called at a negedge: drive a one-cycle start, return at the negedge after E0.
  task automatic start_op(input logic is_mult, input logic [31:0] a, input logic [31:0] b);
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT     = is_mult;
    ctrl_DIV      = ~is_mult;
    @(negedge clock);
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  task automatic wait_rdy(output int lat);
    lat = -1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clock);
      if (data_resultRDY) begin
        lat = k;
        break;
      end
    end
  endtask

  // Reference model: plain signed 64-bit arithmetic on the operand values.
  task automatic ref_op(input logic is_mult, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output logic exc, output int lat);
    longint la, lb, p;
    la = longint'($signed(a));
    lb = longint'($signed(b));
    if (is_mult) begin
      p   = la * lb;
      res = p[31:0];
      exc = (p > 64'sd2147483647) || (p < -64'sd2147483648);
      lat = (a == 0 || b == 0) ? EZ_LAT : 33;
    end else if (b == 0) begin
      res = '0;
      exc = 1'b1;
      lat = 1;
    end else begin
      p   = la / lb;
      res = p[31:0];
      exc = 1'b0;
      lat = 33;
    end
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 4))
      0:       return 32'($signed($urandom_range(0, 2000)) - 1000);
      1:       return 32'h0;
      2: begin
        case ($urandom_range(0, 3))
          0:       return 32'h8000_0000;
          1:       return 32'h7FFF_FFFF;
          2:       return 32'hFFFF_FFFF;
          default: return 32'h0000_0001;
        endcase
      end
      3:       return 32'($signed($urandom_range(0, 131072)) - 65536);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int          lat;
    logic [31:0] r_res;
    logic        r_exc;
    int          r_lat;
    int          seen;

    vecs[0] = '{1'b1, 32'd7,          32'hFFFF_FFFA, 32'hFFFF_FFD6, 1'b0, 33};
    vecs[1] = '{1'b1, 32'h0001_0000,  32'h0001_0000, 32'h0000_0000, 1'b1, 33};
    vecs[2] = '{1'b0, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 1'b0, 33};
    vecs[3] = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 33};
    vecs[4] = '{1'b0, 32'd5,          32'd0,         32'h0000_0000, 1'b1, 1};
    vecs[5] = '{1'b1, 32'd0,          32'd9,         32'h0000_0000, 1'b0, EZ_LAT};
    vecs[6] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 33};

    reset = 1'b1;
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    repeat (3) @(negedge clock);
    chk("reset_result", data_result, 0);
    chk("reset_exc", data_exception, 0);
    chk("reset_rdy", data_resultRDY, 0);
    reset = 1'b0;
    @(negedge clock);

    for (int i = 0; i < 7; i++) begin
      start_op(vecs[i].is_mult, vecs[i].a, vecs[i].b);
      wait_rdy(lat);
      chk($sformatf("vec%0d_lat", i), lat, vecs[i].exp_lat);
      chk($sformatf("vec%0d_res", i), data_result, vecs[i].exp_res);
      chk($sformatf("vec%0d_exc", i), data_exception, vecs[i].exp_exc);
      @(negedge clock);
      chk($sformatf("vec%0d_rdy_pulse", i), data_resultRDY, 0);
    end

    // Outputs hold after completion while idle.
    repeat (3) @(negedge clock);
    chk("hold_res", data_result, 32'h8000_0000);
    chk("hold_exc", data_exception, 1);

    // Abort: MULT 3x4 restarted by DIV 100/7 ten cycles in; only the divide completes.
    start_op(1'b1, 32'd3, 32'd4);
    seen = 0;
    repeat (10) begin
      @(negedge clock);
      if (data_resultRDY) seen++;
    end
    chk("abort_early_rdy", seen, 0);
    start_op(1'b0, 32'd100, 32'd7);
    wait_rdy(lat);
    chk("abort_lat", lat, 33);
    chk("abort_res", data_result, 14);
    chk("abort_exc", data_exception, 0);

    // Start coincident with RDY: accepted, RDY drops at the next edge.
    start_op(1'b0, 32'hFFFF_FFF9, 32'd2);
    chk("coincident_rdy_drop", data_resultRDY, 0);
    wait_rdy(lat);
    chk("coincident_lat", lat, 33);
    chk("coincident_res", data_result, 32'hFFFF_FFFD);

    // Reset mid-op clears outputs and suppresses RDY.
    @(negedge clock);
    start_op(1'b1, 32'd7, 32'hFFFF_FFFA);
    repeat (5) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("midreset_res", data_result, 0);
    chk("midreset_exc", data_exception, 0);
    seen = 0;
    repeat (40) begin
      @(negedge clock);
      if (data_resultRDY) seen++;
    end
    chk("midreset_no_rdy", seen, 0);

    // Randomized operations against the arithmetic model.
    for (int n = 0; n < 40; n++) begin
      logic        is_mult;
      logic [31:0] a, b;
      is_mult = 1'($urandom_range(0, 1));
      a = rand_operand();
      b = rand_operand();
      ref_op(is_mult, a, b, r_res, r_exc, r_lat);
      start_op(is_mult, a, b);
      wait_rdy(lat);
      chk($sformatf("rnd%0d_%s_%h_%h_lat", n, is_mult ? "mul" : "div", a, b), lat, r_lat);
      chk($sformatf("rnd%0d_res", n), data_result, r_res);
      chk($sformatf("rnd%0d_exc", n), data_exception, r_exc);
      @(negedge clock);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
